// File: rtl/sobel_scan_ctrl.sv
// Full-frame raster scan controller feeding a 3x3 edge core through two line buffers.
// Latency: 3 cycles per non-window pixel, 5 per window pixel on a zero-wait bus.
// Backpressure: stalls in RD_WAIT until read_valid and in WR (write_req held) until write_ready.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start / busy / done        frame launch (IDLE only), activity flag, end-of-frame pulse
//   read_req, read_data,
//   read_valid                 one-cycle read request and its returned pixel word
//   write_req, write_data,
//   write_ready                held write request with zero-extended core result
//   addr                       read address in RD_REQ/RD_WAIT, write address in COMPUTE/WR
//   valid_pixels, p00..p22     3x3 window (centre omitted) presented to the core in COMPUTE
//   result                     combinational core output for the presented window
module sobel_scan_ctrl #(
  parameter int          IMG_W    = 28,
  parameter int          IMG_H    = 28,
  parameter int          PIX_W    = 8,
  parameter int          RES_W    = 16,
  parameter logic [31:0] IN_BASE  = 32'h1000_0000,
  parameter logic [31:0] OUT_BASE = 32'h1000_1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    read_req,
  output logic                    write_req,
  output logic [31:0]             addr,
  output logic [31:0]             write_data,
  input  logic [31:0]             read_data,
  input  logic                    read_valid,
  input  logic                    write_ready,
  output logic                    valid_pixels,
  output logic signed [PIX_W-1:0] p00,
  output logic signed [PIX_W-1:0] p01,
  output logic signed [PIX_W-1:0] p02,
  output logic signed [PIX_W-1:0] p10,
  output logic signed [PIX_W-1:0] p12,
  output logic signed [PIX_W-1:0] p20,
  output logic signed [PIX_W-1:0] p21,
  output logic signed [PIX_W-1:0] p22,
  input  logic [RES_W-1:0]        result
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_COMPUTE, S_WR, S_NEXT, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [XW-1:0]            x_q;
  logic [YW-1:0]            y_q;
  logic [31:0]              write_data_q;
  logic signed [PIX_W-1:0]  win_q [3][3];   // [row][col], row 0 = oldest image row
  logic signed [PIX_W-1:0]  lb0_q [IMG_W];  // previous image row
  logic signed [PIX_W-1:0]  lb1_q [IMG_W];  // row before that

  logic                     last_col, last_row, win_complete, rd_accept;
  logic signed [PIX_W-1:0]  pix;
  logic [31:0]              rd_idx, wr_idx, res_ext;

  assign last_col     = (x_q == XW'(IMG_W - 1));
  assign last_row     = (y_q == YW'(IMG_H - 1));
  // Windows straddling a row wrap (x<2) are never complete, so no masking is needed.
  assign win_complete = (x_q >= XW'(2)) && (y_q >= YW'(2));
  assign rd_accept    = (state_q == S_RD_WAIT) && read_valid;
  assign pix          = read_data[PIX_W-1:0];

  // Window centre is (x-1, y-1): linear index y*W+x minus one row and one column.
  assign rd_idx = 32'(y_q) * 32'(IMG_W) + 32'(x_q);
  assign wr_idx = rd_idx - 32'(IMG_W) - 32'd1;

  always_comb begin
    res_ext              = '0;
    res_ext[RES_W-1:0]   = result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b1;
    done         = 1'b0;
    read_req     = 1'b0;
    write_req    = 1'b0;
    valid_pixels = 1'b0;
    addr         = 32'd0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_RD_REQ;
      end
      S_RD_REQ: begin
        read_req = 1'b1;
        addr     = IN_BASE + (rd_idx << 2);
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        addr = IN_BASE + (rd_idx << 2);
        if (read_valid) state_d = win_complete ? S_COMPUTE : S_NEXT;
      end
      S_COMPUTE: begin
        valid_pixels = 1'b1;
        addr         = OUT_BASE + (wr_idx << 2);
        state_d      = S_WR;
      end
      S_WR: begin
        write_req = 1'b1;
        addr      = OUT_BASE + (wr_idx << 2);
        if (write_ready) state_d = S_NEXT;
      end
      S_NEXT: state_d = (last_col && last_row) ? S_DONE : S_RD_REQ;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      write_data_q <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        x_q <= '0;
        y_q <= '0;
      end
      if (state_q == S_NEXT) begin
        if (last_col) begin
          x_q <= '0;
          y_q <= last_row ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
      if (rd_accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1_q[x_q];
        win_q[1][2] <= lb0_q[x_q];
        win_q[2][2] <= pix;
      end
      if (state_q == S_COMPUTE) write_data_q <= res_ext;
    end
  end

  // Line buffers carry no reset: every entry is rewritten before a window uses it.
  always_ff @(posedge clk) begin
    if (rd_accept) begin
      lb1_q[x_q] <= lb0_q[x_q];
      lb0_q[x_q] <= pix;
    end
  end

  assign write_data = write_data_q;
  assign p00 = win_q[0][0];
  assign p01 = win_q[0][1];
  assign p02 = win_q[0][2];
  assign p10 = win_q[1][0];
  assign p12 = win_q[1][2];
  assign p20 = win_q[2][0];
  assign p21 = win_q[2][1];
  assign p22 = win_q[2][2];

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Bench for sobel_scan_ctrl: 28x28 instance against an image/window/result scoreboard,
// plus a 5x4 instance for the parameter-override case.
module tb_sobel_scan_ctrl;

  localparam int          W    = 28;
  localparam int          H    = 28;
  localparam logic [31:0] INB  = 32'h1000_0000;
  localparam logic [31:0] OUTB = 32'h1000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic        busy, done, read_req, write_req, read_valid, write_ready, valid_pixels;
  logic [31:0] addr, write_data, read_data;
  logic signed [7:0] p00, p01, p02, p10, p12, p20, p21, p22;
  logic [15:0] result;

  logic        start_s = 1'b0;
  logic        busy_s, done_s, read_req_s, write_req_s, read_valid_s, write_ready_s, valid_pixels_s;
  logic [31:0] addr_s, write_data_s, read_data_s;
  logic signed [7:0] q00, q01, q02, q10, q12, q20, q21, q22;
  logic [15:0] result_s;

  // Stand-in edge core: mixes gx and gy so every window position influences the result.
  function automatic logic [15:0] core_f(input logic signed [7:0] a00, a01, a02, a10,
                                         a12, a20, a21, a22);
    int gx, gy;
    gx = (int'(a02) + 2 * int'(a12) + int'(a22)) - (int'(a00) + 2 * int'(a10) + int'(a20));
    gy = (int'(a20) + 2 * int'(a21) + int'(a22)) - (int'(a00) + 2 * int'(a01) + int'(a02));
    return 16'(gx * 3 + gy);
  endfunction

  assign result   = core_f(p00, p01, p02, p10, p12, p20, p21, p22);
  assign result_s = core_f(q00, q01, q02, q10, q12, q20, q21, q22);

  sobel_scan_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .read_req(read_req), .write_req(write_req), .addr(addr), .write_data(write_data),
    .read_data(read_data), .read_valid(read_valid), .write_ready(write_ready),
    .valid_pixels(valid_pixels), .p00(p00), .p01(p01), .p02(p02), .p10(p10),
    .p12(p12), .p20(p20), .p21(p21), .p22(p22), .result(result)
  );

  sobel_scan_ctrl #(.IMG_W(5), .IMG_H(4)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
    .read_req(read_req_s), .write_req(write_req_s), .addr(addr_s), .write_data(write_data_s),
    .read_data(read_data_s), .read_valid(read_valid_s), .write_ready(write_ready_s),
    .valid_pixels(valid_pixels_s), .p00(q00), .p01(q01), .p02(q02), .p10(q10),
    .p12(q12), .p20(q20), .p21(q21), .p22(q22), .result(result_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: image, and per-window expected neighbours / address / data.
  logic [7:0]  img [H][W];
  logic [63:0] exp_win[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];

  task automatic build(input int mode);
    logic signed [7:0] a [3][3];
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (mode)
          0:       img[y][x] = 8'(x + y);
          1:       img[y][x] = 8'($urandom);
          default: img[y][x] = 8'hFF;
        endcase
    exp_win.delete(); exp_wa.delete(); exp_wd.delete();
    for (int cy = 1; cy < H - 1; cy++)
      for (int cx = 1; cx < W - 1; cx++) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            a[r][c] = img[cy - 1 + r][cx - 1 + c];
        exp_win.push_back({a[0][0], a[0][1], a[0][2], a[1][0], a[1][2], a[2][0], a[2][1], a[2][2]});
        exp_wa.push_back(OUTB + 32'((cy * W + cx) * 4));
        exp_wd.push_back({16'h0, core_f(a[0][0], a[0][1], a[0][2], a[1][0],
                                        a[1][2], a[2][0], a[2][1], a[2][2])});
      end
  endtask

  // Bus responder and scoreboard for the main instance.
  int          rd_idx, wr_idx, done_cnt, rd_cnt, wr_cnt, rd_dly, wr_dly;
  bit          rd_pend, wr_act, noise, last_rreq;
  logic [31:0] wr_a, wr_d, first_raddr, first_waddr;
  logic [63:0] first_win;

  initial begin : resp
    read_valid = 1'b0; write_ready = 1'b0; read_data = '0;
    forever begin
      @(negedge clk);
      read_valid = 1'b0;
      write_ready = 1'b0;
      if (!rst_n) begin
        rd_pend = 0; wr_act = 0; last_rreq = 0;
        continue;
      end
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          read_valid = 1'b1;
          read_data  = {24'($urandom), img[rd_idx / W][rd_idx % W]};
          rd_pend    = 0;
          rd_idx++;
        end else rd_cnt--;
      end else if (noise && $urandom_range(0, 7) == 0) begin
        read_valid = 1'b1;
        read_data  = $urandom;
      end
      if (read_req) begin
        chk("rd_addr", addr, INB + 32'(rd_idx) * 4);
        chk("rd_rereq", {63'b0, rd_pend}, 64'd0);
        chk("rd_pulse", {63'b0, last_rreq}, 64'd0);
        if (rd_idx == 0) first_raddr = addr;
        rd_pend = 1;
        rd_cnt  = rd_dly;
      end
      last_rreq = read_req;
      if (valid_pixels) begin
        if (wr_idx < exp_win.size())
          chk("win", {p00, p01, p02, p10, p12, p20, p21, p22}, exp_win[wr_idx]);
        else chk("win_extra", 64'(wr_idx), 64'(exp_win.size()));
        if (wr_idx == 0) first_win = {p00, p01, p02, p10, p12, p20, p21, p22};
      end
      if (write_req) begin
        if (!wr_act) begin
          wr_act = 1; wr_cnt = wr_dly; wr_a = addr; wr_d = write_data;
          if (wr_idx == 0) first_waddr = addr;
          if (wr_idx < exp_wa.size()) begin
            chk("wr_addr", addr, exp_wa[wr_idx]);
            chk("wr_data", write_data, exp_wd[wr_idx]);
          end else chk("wr_extra", 64'(wr_idx), 64'(exp_wa.size()));
        end else begin
          chk("wr_hold_addr", addr, wr_a);
          chk("wr_hold_data", write_data, wr_d);
        end
        if (wr_cnt == 0) begin
          write_ready = 1'b1; wr_act = 0; wr_idx++;
        end else wr_cnt--;
      end else if (wr_act) begin
        chk("wr_dropped", {63'b0, write_req}, 64'd1);
        wr_act = 0;
      end
      if (done) done_cnt++;
    end
  end

  // Zero-wait responder for the 5x4 instance; pixel value = raster index.
  int          s_writes;
  bit          s_pend;
  logic [31:0] s_addr, s_wa;
  logic [63:0] s_win;

  initial begin : resp_s
    read_valid_s = 1'b0; write_ready_s = 1'b0; read_data_s = '0; s_writes = 0; s_pend = 0;
    forever begin
      @(negedge clk);
      read_valid_s = 1'b0;
      write_ready_s = 1'b0;
      if (!rst_n) begin s_pend = 0; continue; end
      if (s_pend) begin
        read_valid_s = 1'b1;
        read_data_s  = (s_addr - INB) >> 2;
        s_pend = 0;
      end
      if (read_req_s) begin s_pend = 1; s_addr = addr_s; end
      if (valid_pixels_s && s_writes == 0) s_win = {q00, q01, q02, q10, q12, q20, q21, q22};
      if (write_req_s) begin
        write_ready_s = 1'b1;
        if (s_writes == 0) s_wa = addr_s;
        s_writes++;
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_done"}, {63'b0, done}, 64'd0);
    chk({tag, "_rreq"}, {63'b0, read_req}, 64'd0);
    chk({tag, "_wreq"}, {63'b0, write_req}, 64'd0);
    chk({tag, "_vpix"}, {63'b0, valid_pixels}, 64'd0);
    chk({tag, "_addr"}, {32'b0, addr}, 64'd0);
    chk({tag, "_wdata"}, {32'b0, write_data}, 64'd0);
    chk({tag, "_win"}, {p00, p01, p02, p10, p12, p20, p21, p22}, 64'd0);
  endtask

  task automatic reset_counts();
    rd_idx = 0; wr_idx = 0; done_cnt = 0;
    first_raddr = '1; first_waddr = '1; first_win = '1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30000);
    if (!done) chk("done_timeout", {63'b0, done}, 64'd1);
  endtask

  task automatic launch(input int mode, input int rd, input int wr, input bit nz);
    build(mode);
    rd_dly = rd; wr_dly = wr; noise = nz;
    reset_counts();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_frame(input int mode, input int rd, input int wr, input bit nz);
    launch(mode, rd, wr, nz);
    wait_done();
    repeat (2) @(negedge clk);
    chk("reads", 64'(rd_idx), 64'(W * H));
    chk("writes", 64'(wr_idx), 64'((W - 2) * (H - 2)));
    chk("done_cnt", 64'(done_cnt), 64'd1);
    chk("end_busy", {63'b0, busy}, 64'd0);
    chk("first_raddr", {32'b0, first_raddr}, {32'b0, INB});
  endtask

  initial begin : main
    logic [63:0] s_exp_win, all_neg;
    int n;
    s_exp_win = {8'd0, 8'd1, 8'd2, 8'd5, 8'd7, 8'd10, 8'd11, 8'd12};
    all_neg   = '1;
    rd_dly = 0; wr_dly = 0; noise = 0;
    build(0);
    reset_counts();
    repeat (3) @(negedge clk);
    check_idle("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle");

    // 5x4 instance, raster-index pixels
    start_s = 1'b1; @(negedge clk); start_s = 1'b0;
    n = 0;
    while (!done_s && n < 2000) begin @(negedge clk); n++; end
    chk("s2_done", {63'b0, done_s}, 64'd1);
    chk("s2_writes", 64'(s_writes), 64'd6);
    chk("s2_win", s_win, s_exp_win);
    chk("s2_waddr", {32'b0, s_wa}, {32'b0, OUTB + 32'h18});

    // Zero-wait, pixel = x+y
    run_frame(0, 0, 0, 0);
    chk("s1_first_wa", {32'b0, first_waddr}, 64'h1000_1074);
    chk("s1_p00", {56'b0, first_win[63:56]}, 64'd0);
    chk("s1_p22", {56'b0, first_win[7:0]}, 64'd4);

    // Slow bus: read 3 cycles, write 2 cycles
    run_frame(0, 3, 2, 0);

    // Random pixels with stray read_valid noise
    run_frame(1, 1, 1, 1);

    // All pixels negative (0xFF)
    run_frame(2, 0, 0, 0);
    chk("s4_win_neg", first_win, all_neg);

    // Reset while the 10th write is being held
    launch(0, 1, 3, 0);
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(write_req && wr_idx == 9) && n < 30000);
    chk("s5_reach_wr10", {63'b0, write_req}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_idle("s5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 0, 0, 0);

    // start in RD_WAIT and in the done cycle are ignored
    launch(0, 3, 0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!read_req && n < 100);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("s6_busy_after_done", {63'b0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("s6_still_idle", {63'b0, busy}, 64'd0);
    chk("s6_reads", 64'(rd_idx), 64'(W * H));
    chk("s6_done_cnt", 64'(done_cnt), 64'd1);
    run_frame(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
